// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states
// and the alignment rule used by both the lane logic and the top level.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmemState;

  // A request is misaligned when a half is on an odd byte, a word is not on a
  // word boundary, or the size code is the reserved value 3.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for one memory access: produces the store byte enables
// and replicated store data, and extracts/extends the load value from a RAM
// word. Purely combinational.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wdata,
  input  logic        sext,
  input  logic [31:0] ramWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadWord,
  output logic        misalign
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign loadByte = ramWord[{addrLo, 3'b000} +: 8];
  assign loadHalf = addrLo[1] ? ramWord[31:16] : ramWord[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the
  // destination; errors suppress both the write and the load result.
  always_comb begin
    byteEn    = 4'b0000;
    storeWord = 32'h0;
    loadWord  = 32'h0;
    misalign  = isMisaligned(size, addrLo);
    case (size)
      SZ_BYTE: begin
        byteEn    = 4'b0001 << addrLo;
        storeWord = {4{wdata[7:0]}};
        loadWord  = {{24{sext & loadByte[7]}}, loadByte};
      end
      SZ_HALF: begin
        byteEn    = addrLo[1] ? 4'b1100 : 4'b0011;
        storeWord = {2{wdata[15:0]}};
        loadWord  = {{16{sext & loadHalf[15]}}, loadHalf};
      end
      SZ_WORD: begin
        byteEn    = 4'b1111;
        storeWord = wdata;
        loadWord  = ramWord;
      end
      default: begin
        byteEn    = 4'b0000;
      end
    endcase
    if (misalign) begin
      byteEn   = 4'b0000;
      loadWord = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on an
// internal word RAM after a programmable delay and signals completion with a
// one-cycle data_ok pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam logic [3:0] BUSY_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmemState state, nextState;
  logic [3:0]        counter;
  logic              capWr;
  logic [1:0]        capSize;
  logic              capSext;
  logic [ADDR_W+1:0] capAddr;
  logic [31:0]       capWdata;
  logic              addrErrQ;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              opWr;
  logic [1:0]        opSize;
  logic              opSext;
  logic [ADDR_W+1:0] opAddr;
  logic [31:0]       opWdata;
  logic [31:0]       ramWord;
  logic [3:0]        byteEn;
  logic [31:0]       storeWord;
  logic [31:0]       loadWord;
  logic              misalign;
  logic              enterResp;
  logic              addrUnused;

  assign addrUnused = &{1'b0, addr[31:ADDR_W+2]};

  // With LATENCY=1 the accept edge is also the RAM edge, so the live inputs
  // feed the lane logic while idle and the captured copy is used afterwards.
  assign opWr    = (state == IDLE) ? wr                 : capWr;
  assign opSize  = (state == IDLE) ? size               : capSize;
  assign opSext  = (state == IDLE) ? sext               : capSext;
  assign opAddr  = (state == IDLE) ? addr[ADDR_W+1:0]   : capAddr;
  assign opWdata = (state == IDLE) ? wdata              : capWdata;
  assign ramWord = mem[opAddr[ADDR_W+1:2]];

  dmem_lane uLane (
    .size      (opSize),
    .addrLo    (opAddr[1:0]),
    .wdata     (opWdata),
    .sext      (opSext),
    .ramWord   (ramWord),
    .byteEn    (byteEn),
    .storeWord (storeWord),
    .loadWord  (loadWord),
    .misalign  (misalign)
  );

  // Next-state and handshake outputs; addr_ok depends only on state.
  always_comb begin
    nextState = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = 1'b1;
        if (req) nextState = (LATENCY >= 2) ? BUSY : RESP;
      end
      BUSY: begin
        if (counter == 4'd0) nextState = RESP;
      end
      RESP: begin
        data_ok   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign enterResp = rst && (nextState == RESP);
  assign addr_err  = addrErrQ;

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state <= nextState;
      if (state == IDLE && req) counter <= BUSY_LOAD;
      else if (state == BUSY && counter != 4'd0) counter <= counter - 4'd1;
    end
  end

  // Request capture on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capWr    <= 1'b0;
      capSize  <= SZ_BYTE;
      capSext  <= 1'b0;
      capAddr  <= '0;
      capWdata <= 32'h0;
    end else if (state == IDLE && req) begin
      capWr    <= wr;
      capSize  <= size;
      capSext  <= sext;
      capAddr  <= addr[ADDR_W+1:0];
      capWdata <= wdata;
    end
  end

  // Load result and error flag are registered on the edge entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata    <= 32'h0;
      addrErrQ <= 1'b0;
    end else begin
      addrErrQ <= enterResp ? misalign : 1'b0;
      if (enterResp) begin
        if (misalign)   rdata <= 32'h0;
        else if (!opWr) rdata <= loadWord;
      end
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (enterResp && opWr) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[opAddr[ADDR_W+1:2]][i*8 +: 8] <= storeWord[i*8 +: 8];
      end
    end
  end

endmodule
